// File: rtl/pid_core.sv
// rtl/pid_core.sv - sequential PID stage sharing one multiplier across P/I/D; D path compiled in by PID_DERIV_EN
module pid_core #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic [W-1:0] kp,
    input  logic [W-1:0] ki,
    input  logic [W-1:0] kd,
    input  logic [W-1:0] setpoint,
    input  logic [W-1:0] measurement,
    input  logic         sample_valid,
    input  logic         int_clr,
    output logic [W-1:0] ctrl_out,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun
);
    localparam int AW = 2 * W + 3;
    localparam int PW = 2 * W + 1;
    localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_MUL_D, S_OUT} state_t;

    function automatic logic signed [AW-1:0] sx(input logic [W-1:0] v);
        return {{(AW-W){v[W-1]}}, v};
    endfunction

    function automatic logic [W-1:0] sat_w(input logic signed [AW-1:0] v);
        if (v > SMAX)      return SMAX[W-1:0];
        else if (v < SMIN) return SMIN[W-1:0];
        else               return v[W-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [W-1:0]          sp_q, sp_d, ms_q, ms_d;
    logic [W-1:0]          kp_q, kp_d, ki_q, ki_d;
    logic [W-1:0]          e_q, e_d, integ_q, integ_d, ctrl_out_q, ctrl_out_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic                  out_valid_q, out_valid_d, overrun_q, overrun_d;

    logic [W-1:0]          op_a, op_b, e_w, integ_w;
    logic signed [PW-1:0]  a_x, b_x, prod;
    logic signed [AW-1:0]  prod_ext, term;
`ifdef PID_DERIV_EN
    logic [W-1:0]          kd_q, kd_d, d_q, d_d, e_prev_q, e_prev_d, d_w;
`else
    logic                  kd_unused;
    assign kd_unused = ^kd;
`endif

    // Shared multiplier: signed term times unsigned Q8.8 gain, selected by state
    always_comb begin
        op_a = e_q;
        op_b = kp_q;
        case (state_q)
            S_MUL_I: begin
                op_a = integ_q;
                op_b = ki_q;
            end
`ifdef PID_DERIV_EN
            S_MUL_D: begin
                op_a = d_q;
                op_b = kd_q;
            end
`endif
            default: ;
        endcase
        a_x      = {{(W+1){op_a[W-1]}}, op_a};
        b_x      = {{(W+1){1'b0}}, op_b};
        prod     = a_x * b_x;
        prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
        term     = prod_ext >>> FRAC;
    end

    // Error-stage arithmetic: saturated error, integrator and difference
    always_comb begin
        e_w     = sat_w(sx(sp_q) - sx(ms_q));
        integ_w = sat_w(sx(integ_q) + sx(e_w));
`ifdef PID_DERIV_EN
        d_w     = sat_w(sx(e_w) - sx(e_prev_q));
`endif
    end

    // Next-state and datapath register updates; int_clr overrides the ERR update
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        ms_d        = ms_q;
        kp_d        = kp_q;
        ki_d        = ki_q;
        e_d         = e_q;
        integ_d     = integ_q;
        acc_d       = acc_q;
        ctrl_out_d  = ctrl_out_q;
        out_valid_d = 1'b0;
        overrun_d   = sample_valid && (state_q != S_IDLE);
`ifdef PID_DERIV_EN
        kd_d        = kd_q;
        d_d         = d_q;
        e_prev_d    = e_prev_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    sp_d    = setpoint;
                    ms_d    = measurement;
                    kp_d    = kp;
                    ki_d    = ki;
`ifdef PID_DERIV_EN
                    kd_d    = kd;
`endif
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                e_d      = e_w;
                integ_d  = integ_w;
`ifdef PID_DERIV_EN
                d_d      = d_w;
                e_prev_d = e_w;
`endif
                state_d  = S_MUL_P;
            end
            S_MUL_P: begin
                acc_d   = term;
                state_d = S_MUL_I;
            end
            S_MUL_I: begin
                acc_d   = acc_q + term;
`ifdef PID_DERIV_EN
                state_d = S_MUL_D;
            end
            S_MUL_D: begin
                acc_d   = acc_q + term;
`endif
                state_d = S_OUT;
            end
            S_OUT: begin
                ctrl_out_d  = sat_w(acc_q);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (int_clr) begin
            integ_d  = '0;
`ifdef PID_DERIV_EN
            e_prev_d = '0;
`endif
        end
    end

    // State and datapath registers; reset aborts any computation in flight
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sp_q        <= '0;
            ms_q        <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            e_q         <= '0;
            integ_q     <= '0;
            acc_q       <= '0;
            ctrl_out_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PID_DERIV_EN
            kd_q        <= '0;
            d_q         <= '0;
            e_prev_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            ms_q        <= ms_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            e_q         <= e_d;
            integ_q     <= integ_d;
            acc_q       <= acc_d;
            ctrl_out_q  <= ctrl_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef PID_DERIV_EN
            kd_q        <= kd_d;
            d_q         <= d_d;
            e_prev_q    <= e_prev_d;
`endif
        end
    end

    assign ctrl_out  = ctrl_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule
